module_rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between two writeback requesters: req0 = execute/ALU result, req1 = load/memory unit.
- Fixed priority to req0, with starvation protection that forces a grant to req1 after MAX_WAIT stalled cycles.
- Drives a registered write command into the register file.
- Sits between the pipeline writeback stage and the register file.

---
 rtl/module_rf_wb_arbiter.sv | 92 +++++++++
 tb/tb_module_rf_wb_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/module_rf_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU result (req0) and
// the load unit (req1): req0 has priority, and req1 is forced through after MAX_WAIT stalls.
//   state  | meaning
//   NORMAL | req0 has priority; req1 wins only when req0 is idle
//   STARVE | req1 has waited MAX_WAIT cycles and now has priority
module module_rf_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid0_i,
    input  logic [4:0]  addr0_i,
    input  logic [31:0] data0_i,
    output logic        ready0_o,
    input  logic        valid1_i,
    input  logic [4:0]  addr1_i,
    input  logic [31:0] data1_i,
    output logic        ready1_o,
    output logic        we3_o,
    output logic [4:0]  a3_o,
    output logic [31:0] wd3_o,
    output logic [1:0]  grant_o,
    output logic        starve_o
);

    typedef enum logic {NORMAL, STARVE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer0, xfer1;

    always_comb begin
        ready0_o = 1'b0;
        ready1_o = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (!rst_i) begin
            if (state_q == NORMAL) begin
                ready0_o = valid0_i;
                ready1_o = valid1_i & ~valid0_i;
            end else begin
                ready1_o = valid1_i;
                ready0_o = valid0_i & ~valid1_i;
            end
        end
        xfer0 = valid0_i & ready0_o;
        xfer1 = valid1_i & ready1_o;

        // Stall count only runs while req1 is continuously pending and refused.
        if (!valid1_i || xfer1) begin
            cnt_d = '0;
        end else if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            NORMAL:  if (cnt_d == MAX_CNT) state_d = STARVE;
            STARVE:  if (xfer1 || !valid1_i) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            we3_o   <= 1'b0;
            a3_o    <= '0;
            wd3_o   <= '0;
            grant_o <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // x0 writes still complete the handshake and report the owner, but never enable the write.
            we3_o   <= (xfer0 && addr0_i != 5'd0) || (xfer1 && addr1_i != 5'd0);
            grant_o <= {xfer1, xfer0};
            if (xfer0) begin
                a3_o  <= addr0_i;
                wd3_o <= data0_i;
            end else if (xfer1) begin
                a3_o  <= addr1_i;
                wd3_o <= data1_i;
            end
        end
    end

    assign starve_o = (state_q == STARVE);

endmodule

// File: tb/tb_module_rf_wb_arbiter.sv
// Directed-vector bench for module_rf_wb_arbiter: the stimulus checks handshake outputs and
// queues expected writes, and a negedge monitor compares the registered write port against them.
module tb_module_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid0_i, valid1_i;
    logic [4:0]  addr0_i, addr1_i;
    logic [31:0] data0_i, data1_i;
    logic        ready0_o, ready1_o, we3_o, starve_o;
    logic [4:0]  a3_o;
    logic [31:0] wd3_o;
    logic [1:0]  grant_o;

    module_rf_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid0_i(valid0_i), .addr0_i(addr0_i), .data0_i(data0_i), .ready0_o(ready0_o),
        .valid1_i(valid1_i), .addr1_i(addr1_i), .data1_i(data1_i), .ready1_o(ready1_o),
        .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o), .grant_o(grant_o), .starve_o(starve_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  g;
    } wr_t;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        er0;
        logic        er1;
        logic        est;
    } vec_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("grant", {30'd0, grant_o}, {30'd0, e.g});
                chk("we3", {31'd0, we3_o}, {31'd0, e.we});
                if (e.we) begin
                    chk("a3", {27'd0, a3_o}, {27'd0, e.a});
                    chk("wd3", wd3_o, e.d);
                end
            end else begin
                chk("idle_grant", {30'd0, grant_o}, 32'd0);
                chk("idle_we3", {31'd0, we3_o}, 32'd0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        wr_t w;
        rst_i    = v.rst;
        valid0_i = v.v0; addr0_i = v.a0; data0_i = v.d0;
        valid1_i = v.v1; addr1_i = v.a1; data1_i = v.d1;
        @(negedge clk_i);
        chk("ready0", {31'd0, ready0_o}, {31'd0, v.er0});
        chk("ready1", {31'd0, ready1_o}, {31'd0, v.er1});
        chk("starve", {31'd0, starve_o}, {31'd0, v.est});
        if (v.er0) begin
            w.due = cyc + 1; w.we = (v.a0 != 5'd0); w.a = v.a0; w.d = v.d0; w.g = 2'b01;
            exp_q.push_back(w);
        end
        if (v.er1) begin
            w.due = cyc + 1; w.we = (v.a1 != 5'd0); w.a = v.a1; w.d = v.d1; w.g = 2'b10;
            exp_q.push_back(w);
        end
        @(posedge clk_i);
        #1;
    endtask

    //            rst  v0  a0     d0            v1  a1     d1            er0 er1 est
    vec_t vecs[] = '{
        '{1'b1, 1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,        1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd7,  32'h33,       1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd4,  32'h22,       1'b1, 5'd7,  32'h33,       1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h33,       1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd10, 32'h100,      1'b1, 5'd9,  32'hAA55AA55, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd11, 32'h101,      1'b1, 5'd9,  32'hAA55AA55, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd12, 32'h102,      1'b1, 5'd9,  32'hAA55AA55, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd13, 32'h103,      1'b1, 5'd9,  32'hAA55AA55, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd14, 32'h104,      1'b1, 5'd9,  32'hAA55AA55, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 5'd14, 32'h104,      1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd6,  32'h1,        1'b1, 5'd6,  32'h2,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h2,        1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd12, 32'hC0,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd12, 32'hC1,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd12, 32'hC2,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 5'd12, 32'hC3,       1'b1, 5'd8,  32'h8,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd20, 32'hD0,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd21, 32'hD1,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd22, 32'hD2,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd23, 32'hD3,       1'b1, 5'd8,  32'h8,        1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 5'd24, 32'hD4,       1'b1, 5'd8,  32'h8,        1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0}
    };

    initial begin
        rst_i = 1'b1;
        valid0_i = 1'b0; addr0_i = '0; data0_i = '0;
        valid1_i = 1'b0; addr1_i = '0; data1_i = '0;
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);
        repeat (2) @(posedge clk_i);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
